// File: rtl/demux_sched_pkg.sv
// demux_sched_pkg: shared constants, FSM state type and one-hot helper for the demux select scheduler.
package demux_sched_pkg;
    localparam int CH_NUM = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {IDLE, GRANT} state_t;

    function automatic logic [CH_NUM-1:0] onehot(input logic [SEL_W-1:0] sel);
        logic [CH_NUM-1:0] r_oh;
        r_oh      = '0;
        r_oh[sel] = 1'b1;
        return r_oh;
    endfunction
endpackage

// File: rtl/demux_sel_scheduler_if.sv
// demux_sel_scheduler_if: request/data inputs and select/grant outputs of the demux select scheduler.
interface demux_sel_scheduler_if;
    import demux_sched_pkg::*;
    logic              enable;
    logic [CH_NUM-1:0] req;
    logic              din;
    logic [SEL_W-1:0]  sel;
    logic              dout;
    logic [CH_NUM-1:0] grant;
    logic              busy;
    logic              slot_done;

    modport master (output enable, req, din, input sel, dout, grant, busy, slot_done);
    modport slave  (input enable, req, din, output sel, dout, grant, busy, slot_done);
endinterface

// File: rtl/rr_picker.sv
// rr_picker: combinational winner search; round-robin from last+1, or fixed lowest-index priority
// when DEMUX_SCHED_FIXED_PRIO_EN is defined.
module rr_picker
    import demux_sched_pkg::*;
(
    input  logic [CH_NUM-1:0] req,
    input  logic [SEL_W-1:0]  last,
    output logic [SEL_W-1:0]  winner,
    output logic              any_req
);
    logic [SEL_W-1:0] w_idx;

    assign any_req = |req;

`ifdef DEMUX_SCHED_FIXED_PRIO_EN
    logic w_unused_last;
    assign w_unused_last = ^last;

    always_comb begin
        winner = '0;
        w_idx  = '0;
        for (int k = CH_NUM - 1; k >= 0; k--) begin
            w_idx = SEL_W'(k);
            if (req[w_idx]) winner = w_idx;
        end
    end
`else
    // Scan farthest-first so the nearest set bit after last overwrites the others.
    always_comb begin
        winner = '0;
        w_idx  = '0;
        for (int k = CH_NUM - 1; k >= 0; k--) begin
            w_idx = last + SEL_W'(k + 1);
            if (req[w_idx]) winner = w_idx;
        end
    end
`endif
endmodule

// File: rtl/demux_sel_scheduler.sv
// demux_sel_scheduler: grants one of four channels for HOLD_CYCLES-clock slots and drives demux sel/dout.
// Build option: DEMUX_SCHED_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module demux_sel_scheduler
    import demux_sched_pkg::*;
#(
    parameter int HOLD_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    demux_sel_scheduler_if.slave  bus
);
    localparam int CNT_W = $clog2(HOLD_CYCLES) + 1;

    state_t            r_state, w_state_n;
    logic [CNT_W-1:0]  r_cnt, w_cnt_n;
    logic [SEL_W-1:0]  r_last, w_last_n;
    logic [SEL_W-1:0]  r_sel, w_sel_n;
    logic [CH_NUM-1:0] r_grant, w_grant_n;
    logic [SEL_W-1:0]  w_winner;
    logic              w_any_req;
    logic              w_busy;
    logic              w_slot_done;
    logic              w_start;

    rr_picker u_picker (
        .req     (bus.req),
        .last    (r_last),
        .winner  (w_winner),
        .any_req (w_any_req)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_last  <= 2'd3;
            r_sel   <= '0;
            r_grant <= '0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_last  <= w_last_n;
            r_sel   <= w_sel_n;
            r_grant <= w_grant_n;
        end
    end

    assign w_busy      = (r_state == GRANT);
    assign w_slot_done = w_busy && (r_cnt == '0);
    // A new grant starts from IDLE or directly on a slot's last cycle, so back-to-back slots have no gap.
    assign w_start     = bus.enable && w_any_req && (!w_busy || w_slot_done);

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_last_n  = r_last;
        w_sel_n   = r_sel;
        w_grant_n = r_grant;
        if (w_start) begin
            w_state_n = GRANT;
            w_cnt_n   = CNT_W'(HOLD_CYCLES - 1);
            w_last_n  = w_winner;
            w_sel_n   = w_winner;
            w_grant_n = onehot(w_winner);
        end else if (w_slot_done) begin
            w_state_n = IDLE;
            w_grant_n = '0;
        end else if (w_busy) begin
            w_cnt_n   = r_cnt - 1'b1;
        end
    end

    assign bus.sel       = r_sel;
    assign bus.grant     = r_grant;
    assign bus.busy      = w_busy;
    assign bus.slot_done = w_slot_done;
    assign bus.dout      = bus.din & w_busy;
endmodule

// File: tb/tb_demux_sel_scheduler.sv
// tb_demux_sel_scheduler: directed checks of reset, round-robin order, slot timing, release and async reset.
module tb_demux_sel_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    demux_sel_scheduler_if bus ();

    demux_sel_scheduler #(.HOLD_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [8:0] obs;
    assign obs = {bus.grant, bus.sel, bus.busy, bus.slot_done, bus.dout};

    task automatic apply_reset(input logic [3:0] r, input logic en);
        rst_n      = 1'b0;
        bus.req    = r;
        bus.enable = en;
        bus.din    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [8:0] exp;
        exp        = '0;
        rst_n      = 1'b0;
        bus.req    = 4'b1111;
        bus.enable = 1'b1;
        bus.din    = 1'b1;
        @(negedge clk);
        tests++;
        if (obs !== exp) begin
            failed++;
            $display("FAIL reset_hold: got %b expected %b", obs, exp);
        end
        rst_n = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (obs !== exp) begin
            failed++;
            $display("FAIL reset_async: got %b expected %b", obs, exp);
        end
    endtask

    task automatic test_full_load();
        logic [8:0] exp;
        logic [3:0] oh;
        int ch;
        apply_reset(4'b1111, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            ch  = (i / 4) % 4;
            oh  = 4'b0001 << ch;
            exp = {oh, 2'(ch), 1'b1, (i % 4 == 3), 1'b0};
            tests++;
            if (obs !== exp) begin
                failed++;
                $display("FAIL full_load cyc%0d: got %b expected %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_sparse();
        logic [8:0] exp;
        apply_reset(4'b1010, 1'b1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            exp = ((i / 4) % 2 == 1) ? {4'b1000, 2'd3, 1'b1, (i % 4 == 3), 1'b0}
                                     : {4'b0010, 2'd1, 1'b1, (i % 4 == 3), 1'b0};
            tests++;
            if (obs !== exp) begin
                failed++;
                $display("FAIL sparse cyc%0d: got %b expected %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_single();
        logic [8:0] exp;
        apply_reset(4'b0100, 1'b1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            bus.din = 1'((i + 1) % 2);
            #1;
            exp = {4'b0100, 2'd2, 1'b1, (i % 4 == 3), 1'((i + 1) % 2)};
            tests++;
            if (obs !== exp) begin
                failed++;
                $display("FAIL single cyc%0d: got %b expected %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_release();
        logic [8:0] exp;
        apply_reset(4'b0010, 1'b1);
        bus.din = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            exp = (i < 4) ? {4'b0010, 2'd1, 1'b1, (i == 3), 1'b1}
                          : {4'b0000, 2'd1, 1'b0, 1'b0, 1'b0};
            tests++;
            if (obs !== exp) begin
                failed++;
                $display("FAIL release cyc%0d: got %b expected %b", i, obs, exp);
            end
            if (i == 1) bus.req = 4'b0000;
        end
    endtask

    task automatic test_enable_drop();
        logic [8:0] exp;
        apply_reset(4'b1111, 1'b1);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            exp = (i < 4)  ? {4'b0001, 2'd0, 1'b1, (i == 3), 1'b0} :
                  (i == 6) ? {4'b0010, 2'd1, 1'b1, 1'b0, 1'b0}
                           : {4'b0000, 2'd0, 1'b0, 1'b0, 1'b0};
            tests++;
            if (obs !== exp) begin
                failed++;
                $display("FAIL enable_drop cyc%0d: got %b expected %b", i, obs, exp);
            end
            if (i == 1) bus.enable = 1'b0;
            if (i == 5) bus.enable = 1'b1;
        end
    endtask

    task automatic test_mid_reset();
        logic [8:0] exp;
        apply_reset(4'b0100, 1'b1);
        @(negedge clk);
        exp = {4'b0100, 2'd2, 1'b1, 1'b0, 1'b0};
        tests++;
        if (obs !== exp) begin
            failed++;
            $display("FAIL mid_reset_pre: got %b expected %b", obs, exp);
        end
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        exp = '0;
        tests++;
        if (obs !== exp) begin
            failed++;
            $display("FAIL mid_reset_clear: got %b expected %b", obs, exp);
        end
        bus.req = 4'b0001;
        @(negedge clk);
        tests++;
        if (obs !== exp) begin
            failed++;
            $display("FAIL mid_reset_held: got %b expected %b", obs, exp);
        end
        rst_n = 1'b1;
        @(negedge clk);
        exp = {4'b0001, 2'd0, 1'b1, 1'b0, 1'b0};
        tests++;
        if (obs !== exp) begin
            failed++;
            $display("FAIL mid_reset_regrant: got %b expected %b", obs, exp);
        end
    endtask

    initial begin
        bus.req    = '0;
        bus.enable = 1'b0;
        bus.din    = 1'b0;
        test_reset();
        test_full_load();
        test_sparse();
        test_single();
        test_release();
        test_enable_drop();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/demux_sel_scheduler.md
Name: demux_sel_scheduler

Overview:
- Upstream control stage for the 1-to-4 demultiplexer. Drives its select and data inputs.
- Arbitrates four channel requests round-robin and grants one channel for a fixed slot of HOLD_CYCLES clocks.
- During the slot, presents the granted channel index on sel and gated serial data on dout.
- Output channel steering itself is left to the downstream demux.

Parameters:
- HOLD_CYCLES, 4, slot length in clocks per grant. Legal range is 1 or more.
- CNT_W, $clog2(HOLD_CYCLES)+1, slot counter width (localparam, not overridable).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  allows new grants; does not abort a running slot.
- req  input  4  per-channel request; bit n is channel n.
- din  input  1  serial data to route.
- sel  output  2  granted channel index; feeds the demux select.
- dout  output  1  gated data; feeds the demux data input.
- grant  output  4  one-hot granted channel; 4'b0000 when idle.
- busy  output  1  high while a slot is active.
- slot_done  output  1  high during the final cycle of each slot.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values, applied immediately on rst_n low, including mid-slot:
  - sel=2'b00, dout=0, grant=4'b0000, busy=0, slot_done=0.
  - state=IDLE, counter=0, last pointer=2'd3, so the first search starts at channel 0.
- Winner selection: scan req starting at (last+1) mod 4, ascending with wrap. The first set bit wins.
- IDLE state:
  - If enable and any req bit is set: next cycle enter GRANT.
  - On that transition, register grant=onehot(winner), sel=winner, last=winner, counter=HOLD_CYCLES-1, busy=1.
  - Latency from req sampled to grant visible is 1 clock.
- GRANT state:
  - Counter decrements once per clock.
  - slot_done = (state==GRANT) && (counter==0), combinational.
  - When counter==0 and enable=1 and any req is set: regrant the next winner on the following edge. No idle bubble; back-to-back slots.
  - When counter==0 otherwise: return to IDLE. grant=0 and busy=0 next cycle; sel holds its last value.
- dout = din & busy, combinational, zero latency. dout is forced 0 whenever idle.
- Request drop mid-slot: the slot runs to its full length. There is no early release.
- enable drop mid-slot: the slot completes, then the block returns to IDLE.
- Single requester: the same channel is regranted back-to-back indefinitely.
- HOLD_CYCLES=1: slot_done is high on every GRANT cycle, and the grant can change every clock.
- Invariants: grant is always one-hot or zero, and sel always equals the index of the set grant bit while busy.

Optional Feature:
- Macro: DEMUX_SCHED_FIXED_PRIO_EN.
- Defined: fixed priority. The lowest-numbered set req bit always wins, and the last pointer is ignored (still reset, no functional effect).
- Undefined (default): round-robin as described above.

Decomposition:
- Package demux_sched_pkg contains:
  - constants CH_NUM=4 and SEL_W=2;
  - typedef enum logic {IDLE, GRANT} state_t;
  - a function onehot(sel) returning 4 bits.
- Sub-module rr_picker: purely combinational. Takes req[3:0] and last[1:0]; returns winner[1:0] and any_req.
  - Contains the DEMUX_SCHED_FIXED_PRIO_EN selection.

Test Plan:
- Reset: rst_n=0 with req=4'b1111, din=1 -> sel=00, dout=0, grant=0000, busy=0, slot_done=0.
- Full load: req=4'b1111, enable=1, HOLD_CYCLES=4 -> grant sequence 0001, 0010, 0100, 1000, 0001, each lasting 4 clocks with no gaps; sel 0, 1, 2, 3, 0; slot_done every 4th clock.
- Sparse requests: req=4'b1010 from reset -> grant ch1, then ch3, then ch1; sel 01, 11, 01.
- Single channel: req=4'b0100 -> grant=0100 continuously, sel=10; din toggling 1, 0, 1 appears on dout in the same cycles.
- Release: req dropped to 0000 on cycle 2 of a slot, din=1 -> slot lasts 4 clocks total; the next cycle has grant=0000, busy=0, dout=0, sel unchanged.
- Mid-slot reset: rst_n pulsed low in cycle 2 of a ch2 slot -> outputs cleared asynchronously; after release with req=4'b0001, ch0 is granted 1 clock later.
